// File: rtl/pet_stats_engine.sv
// Virtual pet stat engine: NUM_STATS saturating need counters, tick-driven growth, ASCII care commands, AWAKE/SLEEPING/DEAD FSM.
// Latency: command and tick effects are registered and visible one cycle after the sampling edge; death and auto-wake follow one cycle later.
// Backpressure: none; a non-zero command byte is evaluated once, and 0x00 must be seen before another command is accepted.
module pet_stats_engine #(
   parameter int NUM_STATS = 4,
   parameter int STAT_W    = 5,
   parameter int STAT_MAX  = 15,
   parameter int TICK_DIV  = 27000000,
   parameter int DEATH_EN  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    inputs,
   input  logic [7:0]                    random,
   output logic                          second,
   output logic [NUM_STATS*STAT_W-1:0]   stats,
   output logic [1:0]                    pet_state,
   output logic                          cmd_ack
);

   localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int                ENERGY    = NUM_STATS - 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [STAT_W-1:0] MAX_V     = STAT_W'(STAT_MAX);
   localparam logic [7:0]        DIGIT_END = 8'(48 + NUM_STATS);

   localparam logic [7:0] CMD_EAT   = 8'h65;
   localparam logic [7:0] CMD_PLAY  = 8'h70;
   localparam logic [7:0] CMD_BATH  = 8'h62;
   localparam logic [7:0] CMD_SLEEP = 8'h73;
   localparam logic [7:0] CMD_WAKE  = 8'h77;
   localparam logic [7:0] CMD_DIG0  = 8'h30;

   typedef enum logic [1:0] {
      ST_AWAKE    = 2'd0,
      ST_SLEEPING = 2'd1,
      ST_DEAD     = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  tick_cnt_q;
   logic              tick;
   logic [STAT_W-1:0] stat_q [NUM_STATS];
   logic [STAT_W-1:0] stat_d [NUM_STATS];
   logic              armed_q;
   logic              wake_pend_q;
   logic              wake_pend_d;

   logic              cmd_eval;
   logic              dec_en;
   logic [2:0]        dec_idx;
   logic              go_sleep;
   logic              go_wake;
   logic              cmd_acc;
   logic              live;
   logic              any_max;

   // Only the low three random bits select a stat; the rest are don't-care.
   logic unused_random;
   assign unused_random = ^random[7:3];

   // Apply one cycle of events to a stat: the increment saturates at
   // STAT_MAX on its own, then the net decrements are applied and the
   // result is clamped at zero. A stat sitting at the ceiling with +1/-1
   // therefore lands one below the ceiling rather than staying there.
   function automatic logic [STAT_W-1:0] step_stat(
      input logic [STAT_W-1:0] cur,
      input logic              up,
      input logic [1:0]        down
   );
      int v;
      v = int'(cur);
      if (up && (cur < MAX_V)) v = v + 1;
      v = v - int'(down);
      if (v < 0) v = 0;
      if (v > STAT_MAX) v = STAT_MAX;
      return STAT_W'(v);
   endfunction

   assign tick = (tick_cnt_q == CNT_LAST);
   assign live = (state_q != ST_DEAD);

   // Free-running tick divider: counts 0..TICK_DIV-1 and wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   // Decode the command byte against the current (pre-transition) state.
   always_comb begin
      cmd_eval = armed_q && (inputs != 8'h00);
      dec_en   = 1'b0;
      dec_idx  = 3'd0;
      go_sleep = 1'b0;
      go_wake  = 1'b0;
      if (cmd_eval) begin
         case (state_q)
            ST_AWAKE: begin
               if (inputs == CMD_SLEEP) begin
                  go_sleep = 1'b1;
               end else if (inputs == CMD_EAT) begin
                  dec_en  = 1'b1;
                  dec_idx = 3'd0;
               end else if (inputs == CMD_PLAY) begin
                  dec_en  = 1'b1;
                  dec_idx = 3'd1;
               end else if ((inputs == CMD_BATH) && (NUM_STATS > 2)) begin
                  dec_en  = 1'b1;
                  dec_idx = 3'd2;
               end else if ((inputs >= CMD_DIG0) && (inputs < DIGIT_END)) begin
                  // '0'..'7' carry the stat index in their low three bits.
                  dec_en  = 1'b1;
                  dec_idx = inputs[2:0];
               end
            end
            ST_SLEEPING: begin
               if (inputs == CMD_WAKE) go_wake = 1'b1;
            end
            default: begin
            end
         endcase
      end
      cmd_acc = dec_en | go_sleep | go_wake;
   end

   // Next value of every stat: tick growth, sleep drain on energy, command decrement.
   always_comb begin
      stat_d = stat_q;
      for (int i = 0; i < NUM_STATS; i++) begin
         stat_d[i] = step_stat(
            stat_q[i],
            live && tick && (random[2:0] == 3'(i)),
            {1'b0, (state_q == ST_SLEEPING) && tick && (i == ENERGY)} +
            {1'b0, dec_en && (dec_idx == 3'(i))});
      end
   end

   // Death watches the registered stats, so it lands one cycle after a stat hits the ceiling.
   always_comb begin
      any_max = 1'b0;
      for (int i = 0; i < NUM_STATS; i++) begin
         if (stat_q[i] == MAX_V) any_max = 1'b1;
      end
   end

   // Energy drained to zero by a sleeping tick schedules a wake for the next cycle.
   assign wake_pend_d = (state_q == ST_SLEEPING) && tick && (stat_d[ENERGY] == '0);

   // FSM next state; priority is death, then auto-wake, then the sleep/wake commands.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_AWAKE: begin
            if ((DEATH_EN != 0) && any_max) state_d = ST_DEAD;
            else if (go_sleep)              state_d = ST_SLEEPING;
         end
         ST_SLEEPING: begin
            if ((DEATH_EN != 0) && any_max) state_d = ST_DEAD;
            else if (wake_pend_q)           state_d = ST_AWAKE;
            else if (go_wake)               state_d = ST_AWAKE;
         end
         ST_DEAD: begin
            state_d = ST_DEAD;
         end
         default: begin
            state_d = ST_AWAKE;
         end
      endcase
   end

   // FSM state register; DEAD is left only through reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_AWAKE;
      end else begin
         state_q <= state_d;
      end
   end

   // Stats, animation phase, command arming and the ack pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= '0;
         second      <= 1'b0;
         armed_q     <= 1'b1;
         wake_pend_q <= 1'b0;
         cmd_ack     <= 1'b0;
      end else begin
         stat_q      <= stat_d;
         second      <= tick ? ~second : second;
         // Any non-zero byte disarms (accepted or not); idle re-arms.
         armed_q     <= (inputs == 8'h00);
         wake_pend_q <= wake_pend_d;
         cmd_ack     <= cmd_acc;
      end
   end

   // Flatten the stat array onto the display bus.
   always_comb begin
      stats = '0;
      for (int i = 0; i < NUM_STATS; i++) begin
         stats[i*STAT_W +: STAT_W] = stat_q[i];
      end
   end

   assign pet_state = state_q;

endmodule

// File: tb/tb_pet_stats_engine.sv
// Bench for pet_stats_engine: two instances (4 stats and 6 stats), TICK_DIV=4.
// Stimulus pushes hand-computed expectations tagged with a cycle number;
// a monitor on the falling edge pops and compares them against the DUT.
module tb_pet_stats_engine;

   localparam logic [1:0] AWAKE = 2'd0;
   localparam logic [1:0] SLP   = 2'd1;
   localparam logic [1:0] DEAD  = 2'd2;
   localparam logic [7:0] C_E   = 8'h65;
   localparam logic [7:0] C_B   = 8'h62;
   localparam logic [7:0] C_S   = 8'h73;
   localparam logic [7:0] C_W   = 8'h77;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  inputs = 8'h00;
   logic [7:0]  random = 8'h00;
   logic [7:0]  inputs_b = 8'h00;
   logic [7:0]  random_b = 8'h07;

   logic        second_a, cmd_ack_a;
   logic [19:0] stats_a;
   logic [1:0]  pet_state_a;
   logic        second_b, cmd_ack_b;
   logic [29:0] stats_b;
   logic [1:0]  pet_state_b;

   pet_stats_engine #(.NUM_STATS(4), .STAT_W(5), .STAT_MAX(15), .TICK_DIV(4), .DEATH_EN(1)) dut_a (
      .clk(clk), .reset(reset), .inputs(inputs), .random(random),
      .second(second_a), .stats(stats_a), .pet_state(pet_state_a), .cmd_ack(cmd_ack_a));

   pet_stats_engine #(.NUM_STATS(6), .STAT_W(5), .STAT_MAX(15), .TICK_DIV(4), .DEATH_EN(1)) dut_b (
      .clk(clk), .reset(reset), .inputs(inputs_b), .random(random_b),
      .second(second_b), .stats(stats_b), .pet_state(pet_state_b), .cmd_ack(cmd_ack_b));

   always #5 clk = ~clk;

   typedef struct packed {
      int          cyc;
      int          dut;
      logic [47:0] st;
      logic [1:0]  ps;
      logic        sec;
      logic        ack;
   } exp_t;

   exp_t  q[$];
   string nq[$];
   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   bit    end_req = 1'b0;
   bit    end_done = 1'b0;
   logic [7:0] dcmd [5];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [47:0] pk(input int s0, input int s1, input int s2,
                                      input int s3, input int s4, input int s5);
      logic [47:0] v;
      v = '0;
      v[4:0]   = 5'(s0);
      v[9:5]   = 5'(s1);
      v[14:10] = 5'(s2);
      v[19:15] = 5'(s3);
      v[24:20] = 5'(s4);
      v[29:25] = 5'(s5);
      return v;
   endfunction

   task automatic chk(input int dut, input string nm, input logic [47:0] st,
                      input logic [1:0] ps, input logic sec, input logic ack);
      exp_t e;
      e.cyc = cyc;
      e.dut = dut;
      e.st  = st;
      e.ps  = ps;
      e.sec = sec;
      e.ack = ack;
      q.push_back(e);
      nq.push_back(nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      inputs = 8'h00;
      inputs_b = 8'h00;
      chk(0, "rst_now_a", '0, AWAKE, 1'b0, 1'b0);
      chk(1, "rst_now_b", '0, AWAKE, 1'b0, 1'b0);
      step();
      chk(0, "rst_held_a", '0, AWAKE, 1'b0, 1'b0);
      chk(1, "rst_held_b", '0, AWAKE, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   // Monitor: compare every expectation due at this cycle.
   exp_t        m_e;
   string       m_nm;
   logic [47:0] m_st;
   logic [1:0]  m_ps;
   logic        m_sec;
   logic        m_ack;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         m_e  = q.pop_front();
         m_nm = nq.pop_front();
         if (m_e.dut == 0) begin
            m_st = 48'(stats_a); m_ps = pet_state_a; m_sec = second_a; m_ack = cmd_ack_a;
         end else begin
            m_st = 48'(stats_b); m_ps = pet_state_b; m_sec = second_b; m_ack = cmd_ack_b;
         end
         total = total + 1;
         if (m_e.cyc < cyc) begin
            bad = bad + 1;
            $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", m_nm, m_e.cyc, cyc);
         end else if ({m_st, m_ps, m_sec, m_ack} !== {m_e.st, m_e.ps, m_e.sec, m_e.ack}) begin
            bad = bad + 1;
            $display("FAIL %s cyc=%0d dut=%0d: got stats=%h state=%0d second=%b ack=%b, want stats=%h state=%0d second=%b ack=%b",
                     m_nm, cyc, m_e.dut, m_st, m_ps, m_sec, m_ack, m_e.st, m_e.ps, m_e.sec, m_e.ack);
         end
      end
      if (end_req && !end_done) begin
         end_done = 1'b1;
         total = total + 1;
         if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      dcmd[0] = C_W; dcmd[1] = 8'h00; dcmd[2] = C_S; dcmd[3] = 8'h00; dcmd[4] = C_E;

      do_reset();

      // Growth of stat1 each tick, second toggling, saturation and death.
      random = 8'h01;
      for (int s = 1; s <= 60; s++) begin
         step();
         chk(0, "t1_grow", pk(0, s/4, 0, 0, 0, 0), AWAKE, 1'((s/4) % 2), 1'b0);
      end
      for (int s = 61; s <= 64; s++) begin
         step();
         chk(0, "t1_dead", pk(0, 15, 0, 0, 0, 0), DEAD, (s < 64), 1'b0);
      end
      // Commands in DEAD change nothing; second keeps toggling.
      for (int k = 0; k < 5; k++) begin
         inputs = dcmd[k];
         step();
         chk(0, "t1_dead_cmd", pk(0, 15, 0, 0, 0, 0), DEAD, ((65 + k) >= 68), 1'b0);
      end
      // Reset asserted mid-tick.
      do_reset();

      // Preload stat0 to 3, then a held 'e' acts once.
      random = 8'h00;
      for (int s = 1; s <= 12; s++) begin
         step();
         chk(0, "t2_pre", pk(s/4, 0, 0, 0, 0, 0), AWAKE, 1'((s/4) % 2), 1'b0);
      end
      random = 8'h07;
      inputs = C_E;
      for (int s = 13; s <= 22; s++) begin
         step();
         chk(0, "t2_hold", pk(2, 0, 0, 0, 0, 0), AWAKE, 1'((s/4) % 2), (s == 13));
      end
      inputs = 8'h00; step();
      chk(0, "t2_rearm", pk(2, 0, 0, 0, 0, 0), AWAKE, 1'b1, 1'b0);
      inputs = C_E; step();
      chk(0, "t2_again", pk(1, 0, 0, 0, 0, 0), AWAKE, 1'b0, 1'b1);
      inputs = 8'h00; step();
      chk(0, "t2_idle", pk(1, 0, 0, 0, 0, 0), AWAKE, 1'b0, 1'b0);

      // Energy to 2, sleep, ignored 'e', drain and auto-wake.
      random = 8'h03;
      for (int s = 26; s <= 32; s++) begin
         step();
         chk(0, "t3_energy", pk(1, 0, 0, (s < 28) ? 0 : (s < 32) ? 1 : 2, 0, 0), AWAKE, 1'((s/4) % 2), 1'b0);
      end
      random = 8'h00;
      inputs = C_S; step();
      chk(0, "t3_sleep", pk(1, 0, 0, 2, 0, 0), SLP, 1'b0, 1'b1);
      inputs = 8'h00; step();
      chk(0, "t3_sleep_idle", pk(1, 0, 0, 2, 0, 0), SLP, 1'b0, 1'b0);
      inputs = C_E; step();
      chk(0, "t3_e_ignored", pk(1, 0, 0, 2, 0, 0), SLP, 1'b0, 1'b0);
      step();
      chk(0, "t3_tick1", pk(2, 0, 0, 1, 0, 0), SLP, 1'b1, 1'b0);
      inputs = 8'h00;
      for (int s = 37; s <= 39; s++) begin
         step();
         chk(0, "t3_hold", pk(2, 0, 0, 1, 0, 0), SLP, 1'b1, 1'b0);
      end
      step();
      chk(0, "t3_tick2", pk(3, 0, 0, 0, 0, 0), SLP, 1'b0, 1'b0);
      step();
      chk(0, "t3_autowake", pk(3, 0, 0, 0, 0, 0), AWAKE, 1'b0, 1'b0);
      step();
      chk(0, "t3_awake", pk(3, 0, 0, 0, 0, 0), AWAKE, 1'b0, 1'b0);

      // Stat2 at 14: tick increment and 'b' in the same cycle cancel, no death.
      do_reset();
      random = 8'h02;
      for (int s = 1; s <= 59; s++) begin
         step();
         chk(0, "t4_grow", pk(0, 0, s/4, 0, 0, 0), AWAKE, 1'((s/4) % 2), 1'b0);
      end
      inputs = C_B; step();
      chk(0, "t4_b_on_tick", pk(0, 0, 14, 0, 0, 0), AWAKE, 1'b1, 1'b1);
      inputs = 8'h00;
      for (int s = 61; s <= 62; s++) begin
         step();
         chk(0, "t4_no_death", pk(0, 0, 14, 0, 0, 0), AWAKE, 1'b1, 1'b0);
      end

      // Six-stat instance: digit commands in range and out of range.
      do_reset();
      random = 8'h07;
      random_b = 8'h05;
      for (int s = 1; s <= 8; s++) begin
         step();
         chk(1, "t5_pre", pk(0, 0, 0, 0, 0, s/4), AWAKE, 1'((s/4) % 2), 1'b0);
      end
      random_b = 8'h07;
      inputs_b = 8'h35; step();
      chk(1, "t5_digit5", pk(0, 0, 0, 0, 0, 1), AWAKE, 1'b0, 1'b1);
      inputs_b = 8'h00; step();
      chk(1, "t5_idle", pk(0, 0, 0, 0, 0, 1), AWAKE, 1'b0, 1'b0);
      inputs_b = 8'h36; step();
      chk(1, "t5_digit6_ign", pk(0, 0, 0, 0, 0, 1), AWAKE, 1'b0, 1'b0);
      inputs_b = 8'h00; step();
      chk(1, "t5_tick", pk(0, 0, 0, 0, 0, 1), AWAKE, 1'b1, 1'b0);
      inputs_b = 8'h30; step();
      chk(1, "t5_digit0_sat", pk(0, 0, 0, 0, 0, 1), AWAKE, 1'b1, 1'b1);
      inputs_b = 8'h00; step();
      chk(1, "t5_end", pk(0, 0, 0, 0, 0, 1), AWAKE, 1'b1, 1'b0);
      chk(0, "t5_a_idle", '0, AWAKE, 1'b1, 1'b0);

      step();
      end_req = 1'b1;
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pet_stats_engine.md
# pet_stats_engine

Parametrised stat engine for the virtual pet, replacing the fixed four-stat block. Holds `NUM_STATS` saturating need counters that grow on a programmable tick, decrements them on single-shot ASCII care commands, and runs an explicit AWAKE/SLEEPING/DEAD state machine with auto-wake. It sits between the UART command decoder and the display/animation logic, which consume the flattened stat bus, `pet_state` and `second`.

## Interface
- `NUM_STATS`, 4: number of stat channels, 2..8. Stat 0 is hunger, 1 happiness, 2 hygiene, `NUM_STATS-1` energy.
- `STAT_W`, 5: width of each stat counter.
- `STAT_MAX`, 15: saturation and death threshold. Must be < 2^`STAT_W`.
- `TICK_DIV`, 27000000: clock cycles per tick.
- `DEATH_EN`, 1: when 0, the DEAD state is unreachable.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `inputs` input 8: command byte (ASCII). 0x00 means idle.
- `random` input 8: free-running random value, sampled on tick.
- `second` output 1: toggles every tick (animation phase).
- `stats` output `NUM_STATS*STAT_W`: stat i occupies bits [i*STAT_W +: STAT_W].
- `pet_state` output 2: 0 = AWAKE, 1 = SLEEPING, 2 = DEAD.
- `cmd_ack` output 1: one-cycle pulse when a command is accepted.

## Operation
- Reset values: all stats 0, `second`=0, `pet_state`=AWAKE, `cmd_ack`=0, tick counter 0, command armed.
- Tick counter:
  - Counts 0..`TICK_DIV`-1 and wraps to 0.
  - `tick` is internal and high for the single cycle where count == `TICK_DIV`-1.
- On tick, in AWAKE or SLEEPING:
  - `second` toggles.
  - If `random[2:0]` < `NUM_STATS`, stat[`random[2:0]`] increments, saturating at `STAT_MAX`.
  - In SLEEPING, energy additionally decrements, saturating at 0.
- In DEAD, `second` still toggles on tick; stats freeze.
- Command arming:
  - A non-zero `inputs` is evaluated only while armed.
  - Evaluation disarms, whether or not the command was accepted.
  - `inputs`==0x00 re-arms.
  - A held byte therefore acts exactly once.
- Accepted commands and effects:
  - In AWAKE only: 'e' (0x65) decrements stat 0; 'p' (0x70) decrements stat 1; 'b' (0x62) decrements stat 2.
  - In AWAKE only: ASCII '0'+i, for i < `NUM_STATS`, decrements stat i.
  - 's' (0x73): AWAKE→SLEEPING.
  - 'w' (0x77): SLEEPING→AWAKE.
  - All decrements saturate at 0.
  - Any other byte, or a command invalid in the current state, is ignored with no `cmd_ack`, but still disarms.
- State transitions:
  - AWAKE→SLEEPING on 's'.
  - SLEEPING→AWAKE on 'w', or automatically when energy is 0 after a tick update.
  - AWAKE/SLEEPING→DEAD when any stat == `STAT_MAX` and `DEATH_EN`=1.
  - DEAD is exited only by `reset`.
- Simultaneous events on one stat in one cycle (tick increment, sleep decrement, command decrement): the net sum is applied, then clamped to [0, `STAT_MAX`]. Example: stat at `STAT_MAX` with +1 and −1 gives `STAT_MAX`−1.
- Priority when several transitions apply in one cycle: DEAD > auto-wake > 'w'/'s'.

## Timing
- Stats, `pet_state`, `second` and `cmd_ack` are all registered.
- Command: `inputs` sampled at edge N. The stat or state change and `cmd_ack`=1 are visible after edge N; `cmd_ack` returns to 0 after edge N+1.
- Tick effects are visible after the edge on which count == `TICK_DIV`-1. Period is exactly `TICK_DIV` cycles.
- Death detection: a stat reaching `STAT_MAX` after edge N gives `pet_state`=DEAD after edge N+1. Commands sampled at edge N+1 are still evaluated against the pre-death state.
- Auto-wake: energy reaching 0 at tick edge N gives `pet_state`=AWAKE after edge N+1.
- Reset asserted mid-tick or mid-command immediately clears all state and outputs. The first tick after release occurs `TICK_DIV` cycles later.

## Test plan
Benches use `TICK_DIV`=4.
- Reset then idle, `random`=0x01 → stat1 increments after every 4th cycle, `second` toggles each tick, and stat1 saturates and `pet_state`=DEAD one cycle after stat1 reaches 15.
- Preload stat0=3 via ticks, hold `inputs`=0x65 for 10 cycles → stat0=2 exactly once, single `cmd_ack` pulse; after 0x00 then 0x65 again → stat0=1.
- 's' in AWAKE → SLEEPING; then 'e' → ignored, no `cmd_ack`; energy=2 with `random`=0x00 → energy 1, then 0, then `pet_state`=AWAKE the cycle after.
- Stat2=15 reached while 'b' arrives on the same tick cycle with `random`=0x02 → stat2 stays 14, no death.
- `NUM_STATS`=6, `inputs`='5' → stat5 decrements; `inputs`='6' → ignored, no `cmd_ack`.
- DEAD state, then 'w'/'s'/'e' → no change, no `cmd_ack`; `reset` pulse mid-tick → all stats 0, AWAKE, `second`=0.
